bmp_slice_streamer: RTL and testbench
=====================================

# bmp_slice_streamer

Parametrised bitmap slice streamer for the compare-accumulate datapath. It latches a W×H monochrome bitmap in one write and serves it to the ALU on request, one slice at a time, over three independent request/valid channels:
- column slices, right to left;
- top-row slices, descending from the last row;
- bottom-row slices, ascending from row 0.

Each channel tracks exhaustion, and the top/bottom pair reports when the two row pointers cross.

## Interface
Parameters:
- W, 24, bitmap width in bits (columns); ≥2
- H, 64, bitmap height in rows; ≥2
- CW, $clog2(W), column pointer width (derived)
- RW, $clog2(H), row pointer width (derived)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wren  in  1  load strobe; latch bmpin this cycle
- bmpin  in  W*H  bitmap; row r = bmpin[(r+1)*W-1 : r*W]
- col_req  in  1  request next column slice
- top_req  in  1  request next top-row slice
- bot_req  in  1  request next bottom-row slice
- col_out  out  H  column slice; col_out[H-1-r] = bit of row r
- top_out  out  W  top-row slice
- bot_out  out  W  bottom-row slice
- col_valid  out  1  one-cycle pulse, col_out updated
- top_valid  out  1  one-cycle pulse, top_out updated
- bot_valid  out  1  one-cycle pulse, bot_out updated
- col_last  out  1  high with the col_valid of column 0
- col_empty  out  1  all W columns delivered
- rows_met  out  1  top pointer below bottom pointer (every row delivered by at least one channel)
- alustart  out  1  one-cycle pulse, the cycle after a load
- loaded  out  1  a bitmap is held

## Operation
- States: EMPTY (after reset) and LOADED. wren moves either state to LOADED and reloads the bitmap. There is no exit to EMPTY except reset.
- In EMPTY, all requests are ignored and no valid pulse is issued.
- On load:
  - data ← bmpin
  - colptr ← W-1, topptr ← H-1, botptr ← 0
  - col_empty ← 0, rows_met ← 0, alustart ← 1 on the next edge
- Column channel:
  - A col_req with col_empty=0 registers col_out ← column[colptr] and pulses col_valid.
  - col_last = (colptr==0).
  - If colptr==0, col_empty ← 1 and colptr holds; otherwise colptr decrements.
  - A request with col_empty=1 is dropped: no pulse, outputs hold.
- Top channel:
  - top_req registers top_out ← row[topptr] and pulses top_valid.
  - topptr decrements and saturates at 0. A request at 0 re-delivers row 0.
- Bottom channel:
  - bot_req registers bot_out ← row[botptr] and pulses bot_valid.
  - botptr increments and saturates at H-1.
- rows_met is combinational: loaded & (topptr < botptr), evaluated on the post-update pointers. The row channels keep serving after rows_met.
- Channels are independent. Simultaneous requests on all three channels are all served in the same cycle.
- wren together with any request: the load wins and the requests are dropped. Valid pulses are 0 next cycle and pointers take their load values.
- Held req level: each cycle with req=1 is a separate request. There is no edge detection.
- Slice outputs hold their last value between pulses.

## Timing
- Reset values:
  - col_out, top_out, bot_out = 0
  - all valids = 0, col_last = 0, col_empty = 0, rows_met = 0, alustart = 0, loaded = 0
  - data = 0, colptr = W-1, topptr = H-1, botptr = 0
- Request latency: req sampled at edge N produces the slice and a valid pulse visible after edge N. This gives 1-cycle latency and a throughput of 1 slice per cycle per channel.
- Load: wren at edge N gives loaded=1 and alustart=1 after edge N+1. alustart is high for exactly one cycle. A request at edge N+1 is served from the new data.
- Reset mid-stream: asserting rst_n low immediately forces all outputs to their reset values. The block returns to EMPTY.
- No combinational path from any input to any output other than through registers. rows_met is derived from registers only.

## Test plan
- Reset then requests with no load: W=24, H=64; col_req/top_req/bot_req held 5 cycles -> no valid pulses, loaded=0, all outputs 0.
- Column sweep: load bmpin with only bit 23 set (row 0, col 23); col_req for 25 cycles ->
  - first col_out = 64'h8000_0000_0000_0000, then 23 zero slices;
  - col_last with the 24th pulse, col_empty=1 after it;
  - 25th request gives no pulse.
- Row crossing: load a pattern with row r = r (24-bit); top_req and bot_req together each cycle ->
  - top_out 63,62,…; bot_out 0,1,…;
  - rows_met rises after the 32nd pair (topptr=31, botptr=32).
- Load collision: wren and col_req in the same cycle mid-sweep -> no col_valid next cycle, alustart pulses, next col_req delivers column 23 of the new bitmap.
- Async reset mid-stream: drop rst_n between edges during a sweep -> outputs 0 before the next edge, loaded=0; after release, requests are ignored until wren.
- Parametrisation: W=8, H=4 instance, same column and row sweeps -> 8 column pulses with 4-bit slices, col_last on the 8th; rows_met after 2 paired row requests.

Source files
------------

// File: rtl/bmp_slice_streamer_if.sv
// Request/slice bundle between the bitmap slice streamer and its client (ALU side).
interface bmp_slice_streamer_if #(
  parameter int W = 24,
  parameter int H = 64
);
  logic           wren;
  logic [W*H-1:0] bmpin;
  logic           col_req;
  logic           top_req;
  logic           bot_req;
  logic [H-1:0]   col_out;
  logic [W-1:0]   top_out;
  logic [W-1:0]   bot_out;
  logic           col_valid;
  logic           top_valid;
  logic           bot_valid;
  logic           col_last;
  logic           col_empty;
  logic           rows_met;
  logic           alustart;
  logic           loaded;

  modport master (
    output wren, bmpin, col_req, top_req, bot_req,
    input  col_out, top_out, bot_out, col_valid, top_valid, bot_valid,
           col_last, col_empty, rows_met, alustart, loaded
  );

  modport slave (
    input  wren, bmpin, col_req, top_req, bot_req,
    output col_out, top_out, bot_out, col_valid, top_valid, bot_valid,
           col_last, col_empty, rows_met, alustart, loaded
  );
endinterface

// File: rtl/bmp_slice_streamer.sv
// Latches a WxH bitmap and streams column slices (right to left) plus top-down
// and bottom-up row slices over three independent request/valid channels.
module bmp_slice_streamer #(
  parameter int W  = 24,
  parameter int H  = 64,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input logic             clk,
  input logic             rst_n,
  bmp_slice_streamer_if.slave bus
);

  typedef enum logic {EMPTY, LOADED} state_t;

  state_t         state_q, state_d;
  logic [W*H-1:0] data_q, data_d;
  logic [CW-1:0]  colptr_q, colptr_d;
  logic [RW-1:0]  topptr_q, topptr_d;
  logic [RW-1:0]  botptr_q, botptr_d;
  logic [H-1:0]   col_q, col_d;
  logic [W-1:0]   top_q, top_d;
  logic [W-1:0]   bot_q, bot_d;
  logic           colv_q, colv_d;
  logic           topv_q, topv_d;
  logic           botv_q, botv_d;
  logic           last_q, last_d;
  logic           empty_q, empty_d;
  logic           pend_q, pend_d;
  logic           alu_q, alu_d;
  logic           loaded_q, loaded_d;

  logic [W-1:0]   row_w [H];
  logic [H-1:0]   col_sel;
  logic           live, col_fire, top_fire, bot_fire;

  // Row r sits at bmpin[r*W +: W]; column slices put row 0 in the MSB.
  for (genvar r = 0; r < H; r++) begin : g_row
    assign row_w[r]       = data_q[r*W +: W];
    assign col_sel[H-1-r] = row_w[r][colptr_q];
  end

  always_comb begin
    state_d = state_q;
    if (bus.wren) state_d = LOADED;
  end

  // A load in the same cycle drops every request.
  assign live     = (state_q == LOADED) & ~bus.wren;
  assign col_fire = live & bus.col_req & ~empty_q;
  assign top_fire = live & bus.top_req;
  assign bot_fire = live & bus.bot_req;

  always_comb begin
    data_d   = data_q;
    colptr_d = colptr_q;
    topptr_d = topptr_q;
    botptr_d = botptr_q;
    col_d    = col_q;
    top_d    = top_q;
    bot_d    = bot_q;
    colv_d   = col_fire;
    topv_d   = top_fire;
    botv_d   = bot_fire;
    last_d   = col_fire & (colptr_q == '0);
    empty_d  = empty_q;
    pend_d   = bus.wren;
    // alustart and loaded trail the data load by one cycle.
    alu_d    = pend_q;
    loaded_d = (state_q == LOADED);

    if (bus.wren) begin
      data_d   = bus.bmpin;
      colptr_d = CW'(W-1);
      topptr_d = RW'(H-1);
      botptr_d = '0;
      empty_d  = 1'b0;
    end

    if (col_fire) begin
      col_d = col_sel;
      if (colptr_q == '0) empty_d  = 1'b1;
      else                colptr_d = colptr_q - 1'b1;
    end

    if (top_fire) begin
      top_d = row_w[topptr_q];
      if (topptr_q != '0) topptr_d = topptr_q - 1'b1;
    end

    if (bot_fire) begin
      bot_d = row_w[botptr_q];
      if (botptr_q != RW'(H-1)) botptr_d = botptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      colptr_q <= CW'(W-1);
      topptr_q <= RW'(H-1);
      botptr_q <= '0;
      col_q    <= '0;
      top_q    <= '0;
      bot_q    <= '0;
      colv_q   <= 1'b0;
      topv_q   <= 1'b0;
      botv_q   <= 1'b0;
      last_q   <= 1'b0;
      empty_q  <= 1'b0;
      pend_q   <= 1'b0;
      alu_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      colptr_q <= colptr_d;
      topptr_q <= topptr_d;
      botptr_q <= botptr_d;
      col_q    <= col_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      colv_q   <= colv_d;
      topv_q   <= topv_d;
      botv_q   <= botv_d;
      last_q   <= last_d;
      empty_q  <= empty_d;
      pend_q   <= pend_d;
      alu_q    <= alu_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.col_out   = col_q;
  assign bus.top_out   = top_q;
  assign bus.bot_out   = bot_q;
  assign bus.col_valid = colv_q;
  assign bus.top_valid = topv_q;
  assign bus.bot_valid = botv_q;
  assign bus.col_last  = last_q;
  assign bus.col_empty = empty_q;
  assign bus.rows_met  = loaded_q & (topptr_q < botptr_q);
  assign bus.alustart  = alu_q;
  assign bus.loaded    = loaded_q;

endmodule

// File: tb/tb_bmp_slice_streamer.sv
// Randomized bench for bmp_slice_streamer against a bitmap-level reference model.
module tb_bmp_slice_streamer;
  localparam int W  = 24;
  localparam int H  = 64;
  localparam int SW = 8;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bmp_slice_streamer_if #(.W(W), .H(H))   bif ();
  bmp_slice_streamer_if #(.W(SW), .H(SH)) sif ();

  bmp_slice_streamer #(.W(W), .H(H))   u_dut   (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
  bmp_slice_streamer #(.W(SW), .H(SH)) u_small (.clk(clk), .rst_n(rst_n), .bus(sif.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bitmap plus which slice each channel hands out next.
  logic [W*H-1:0] m_bmp;
  bit             m_on, m_pend, m_empty;
  int             m_col, m_top, m_bot;
  logic [H-1:0]   e_col;
  logic [W-1:0]   e_top, e_bot;
  bit             e_cv, e_tv, e_bv, e_last, e_alu, e_loaded;

  function automatic logic [H-1:0] col_of(input logic [W*H-1:0] bm, input int c);
    logic [H-1:0] s;
    for (int r = 0; r < H; r++) s[H-1-r] = bm[r*W + c];
    return s;
  endfunction

  function automatic logic [W-1:0] row_of(input logic [W*H-1:0] bm, input int r);
    return bm[r*W +: W];
  endfunction

  function automatic logic [W*H-1:0] rand_bmp();
    logic [W*H-1:0] b;
    for (int i = 0; i < W*H; i++) b[i] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  task automatic model_reset();
    m_bmp = '0; m_on = 0; m_pend = 0; m_empty = 0;
    m_col = W-1; m_top = H-1; m_bot = 0;
    e_col = '0; e_top = '0; e_bot = '0;
    e_cv = 0; e_tv = 0; e_bv = 0; e_last = 0; e_alu = 0; e_loaded = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [W*H-1:0] bmp, input bit c, input bit t, input bit b);
    e_cv = 0; e_tv = 0; e_bv = 0; e_last = 0;
    e_alu    = m_pend;
    m_pend   = wr;
    e_loaded = m_on;
    if (wr) begin
      m_bmp = bmp; m_col = W-1; m_top = H-1; m_bot = 0; m_empty = 0; m_on = 1;
    end else if (m_on) begin
      if (c && !m_empty) begin
        e_col = col_of(m_bmp, m_col); e_cv = 1; e_last = (m_col == 0);
        if (m_col == 0) m_empty = 1; else m_col--;
      end
      if (t) begin
        e_top = row_of(m_bmp, m_top); e_tv = 1;
        if (m_top > 0) m_top--;
      end
      if (b) begin
        e_bot = row_of(m_bmp, m_bot); e_bv = 1;
        if (m_bot < H-1) m_bot++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/col_out"},   bif.col_out,   e_col);
    check({tag, "/top_out"},   bif.top_out,   e_top);
    check({tag, "/bot_out"},   bif.bot_out,   e_bot);
    check({tag, "/col_valid"}, bif.col_valid, e_cv);
    check({tag, "/top_valid"}, bif.top_valid, e_tv);
    check({tag, "/bot_valid"}, bif.bot_valid, e_bv);
    check({tag, "/col_last"},  bif.col_last,  e_last);
    check({tag, "/col_empty"}, bif.col_empty, m_empty);
    check({tag, "/rows_met"},  bif.rows_met,  e_loaded && (m_top < m_bot));
    check({tag, "/alustart"},  bif.alustart,  e_alu);
    check({tag, "/loaded"},    bif.loaded,    e_loaded);
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic step(input bit wr, input logic [W*H-1:0] bmp, input bit c, input bit t,
                      input bit b, input string tag);
    bif.wren = wr; bif.bmpin = bmp; bif.col_req = c; bif.top_req = t; bif.bot_req = b;
    @(posedge clk);
    model_edge(wr, bmp, c, t, b);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic sstep(input bit wr, input logic [SW*SH-1:0] bmp, input bit c, input bit t, input bit b);
    sif.wren = wr; sif.bmpin = bmp; sif.col_req = c; sif.top_req = t; sif.bot_req = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W*H-1:0]   pat, pat2;
  logic [SW*SH-1:0] sp;
  logic [SH-1:0]    ec;

  initial begin
    rst_n = 1'b0;
    bif.wren = 0; bif.bmpin = '0; bif.col_req = 0; bif.top_req = 0; bif.bot_req = 0;
    sif.wren = 0; sif.bmpin = '0; sif.col_req = 0; sif.top_req = 0; sif.bot_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("rst");
    rst_n = 1'b1;

    // Requests with nothing loaded are ignored.
    for (int i = 0; i < 5; i++) step(0, '0, 1, 1, 1, "noload");

    // Column sweep of a single set pixel at row 0, column 23.
    pat = '0; pat[23] = 1'b1;
    step(1, pat, 0, 0, 0, "ldc");
    for (int i = 0; i < 25; i++) begin
      step(0, pat, 1, 0, 0, "csw");
      if (i == 0)  check("col_first", bif.col_out, 64'h8000_0000_0000_0000);
      if (i == 22) check("col_last_early", bif.col_last, 1'b0);
      if (i == 23) begin
        check("col_last_24", bif.col_last, 1'b1);
        check("col_empty_24", bif.col_empty, 1'b1);
      end
      if (i == 24) check("col_drop_25", bif.col_valid, 1'b0);
    end

    // Row crossing: row r holds the value r.
    for (int r = 0; r < H; r++) pat[r*W +: W] = W'(r);
    step(1, pat, 0, 0, 0, "ldr");
    for (int i = 0; i < 34; i++) begin
      step(0, pat, 0, 1, 1, "rsw");
      check("row_top", bif.top_out, 64'(H-1-i));
      check("row_bot", bif.bot_out, 64'(i));
      check("row_met", bif.rows_met, 64'(i >= 31));
    end

    // Load colliding with a column request mid-sweep.
    pat  = rand_bmp();
    pat2 = rand_bmp();
    step(1, pat, 0, 0, 0, "ldx");
    for (int i = 0; i < 3; i++) step(0, pat, 1, 0, 0, "xsw");
    step(1, pat2, 1, 0, 0, "coll");
    check("coll_novalid", bif.col_valid, 1'b0);
    step(0, pat2, 0, 0, 0, "coll_idle");
    check("coll_alustart", bif.alustart, 1'b1);
    step(0, pat2, 1, 0, 0, "coll_col");
    check("coll_col23", bif.col_out, 64'(col_of(pat2, W-1)));

    // Randomized traffic with occasional reloads.
    for (int i = 0; i < 400; i++) begin
      bit wr;
      wr = ($urandom_range(0, 24) == 0);
      if (wr) pat = rand_bmp();
      step(wr, pat, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "rnd");
    end

    // Asynchronous reset between edges during a sweep.
    step(1, pat, 0, 0, 0, "ldar");
    for (int i = 0; i < 4; i++) step(0, pat, 1, 1, 1, "arsw");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, pat, 1, 1, 1, "postrst");
    step(1, pat, 0, 0, 0, "reload");
    step(0, pat, 1, 1, 1, "reload_req");
    bif.wren = 0; bif.col_req = 0; bif.top_req = 0; bif.bot_req = 0;

    // Small geometry instance.
    for (int i = 0; i < SW*SH; i++) sp[i] = 1'($urandom_range(0, 1));
    sp[SW-1] = 1'b1;
    sstep(1, sp, 0, 0, 0);
    check("s_rows_met0", sif.rows_met, 1'b0);
    for (int i = 0; i < SW; i++) begin
      sstep(0, sp, 1, 0, 0);
      for (int r = 0; r < SH; r++) ec[SH-1-r] = sp[r*SW + (SW-1-i)];
      check("s_col_valid", sif.col_valid, 1'b1);
      check("s_col_out", sif.col_out, ec);
      check("s_col_last", sif.col_last, 64'(i == SW-1));
    end
    sstep(0, sp, 1, 0, 0);
    check("s_col_drop", sif.col_valid, 1'b0);
    check("s_col_empty", sif.col_empty, 1'b1);
    for (int i = 0; i < 2; i++) begin
      sstep(0, sp, 0, 1, 1);
      check("s_top", sif.top_out, sp[(SH-1-i)*SW +: SW]);
      check("s_bot", sif.bot_out, sp[i*SW +: SW]);
      check("s_rows_met", sif.rows_met, 64'(i == 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
